// File: rtl/fw_hex_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fw_hex_loader_if
//  Description : Character-stream and memory-write bus of the hex loader.
//  Revision    : 1.0
// ============================================================================
interface fw_hex_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [7:0]            char_in;
    logic                  char_valid;
    logic                  char_ready;
    logic                  eof;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;

    modport master (
        output char_in, char_valid, eof,
        input  char_ready, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  char_in, char_valid, eof,
        output char_ready, mem_we, mem_addr, mem_din
    );
endinterface
`default_nettype wire

// File: rtl/fw_hex_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fw_hex_loader
//  Description : Parses an ASCII hex stream into words and writes them to
//                memory; holds the CPU in reset until the load is complete.
//  Revision    : 1.0
// ============================================================================
module fw_hex_loader #(
    parameter int              ADDR_WIDTH  = 16,
    parameter int              DATA_WIDTH  = 8,
    parameter int unsigned     BASE_ADDR   = 'h0200,
    parameter longint unsigned DEPTH       = 65536,
    parameter int              COUNT_WIDTH = 17
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    input  wire logic                   start,
    fw_hex_loader_if.slave              bus,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  error_code,
    output logic [COUNT_WIDTH-1:0]      word_count,
    output logic                        cpu_reset_n
);
    localparam int c_nibbles = DATA_WIDTH / 4;
    localparam int c_kw      = (c_nibbles > 1) ? $clog2(c_nibbles) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_base = ADDR_WIDTH'(BASE_ADDR);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_word    = 3'd1;
    localparam logic [2:0] c_st_org     = 3'd2;
    localparam logic [2:0] c_st_comment = 3'd3;
    localparam logic [2:0] c_st_write   = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;
    localparam logic [2:0] c_st_err     = 3'd6;

    localparam logic [1:0] c_err_char  = 2'b01;
    localparam logic [1:0] c_err_split = 2'b10;
    localparam logic [1:0] c_err_range = 2'b11;

    logic [2:0]             r_state;
    logic [c_kw-1:0]        r_nib;
    logic [DATA_WIDTH-1:0]  r_word;
    logic [ADDR_WIDTH-1:0]  r_org;
    logic                   r_org_any;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_mem_we;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_din;
    logic [1:0]             r_err;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_eof_pending;

    logic                   w_is_hex;
    logic [3:0]             w_nib;
    logic                   w_is_sep;
    logic                   w_is_hash;
    logic                   w_is_at;
    logic                   w_is_lf;
    logic                   w_char_ready;
    logic                   w_accept;
    logic                   w_eof_now;
    logic                   w_in_range;
    logic                   w_last;
    logic [DATA_WIDTH-1:0]  w_word_next;
    logic [ADDR_WIDTH-1:0]  w_org_next;

    // Each character decodes on its own, so mixed case within a word is legal
    always_comb begin
        w_is_hex = 1'b0;
        w_nib    = 4'h0;
        if (bus.char_in >= 8'h30 && bus.char_in <= 8'h39) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(bus.char_in - 8'h30);
        end else if (bus.char_in >= 8'h41 && bus.char_in <= 8'h46) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(bus.char_in - 8'h37);
        end else if (bus.char_in >= 8'h61 && bus.char_in <= 8'h66) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(bus.char_in - 8'h57);
        end
    end

    assign w_is_lf   = (bus.char_in == 8'h0A);
    assign w_is_sep  = (bus.char_in == 8'h20) || (bus.char_in == 8'h09) ||
                       (bus.char_in == 8'h0D) || w_is_lf || (bus.char_in == 8'h00);
    assign w_is_hash = (bus.char_in == 8'h23);
    assign w_is_at   = (bus.char_in == 8'h40);

    assign w_char_ready = (r_state == c_st_word) || (r_state == c_st_org) ||
                          (r_state == c_st_comment);
    assign w_accept     = bus.char_valid & w_char_ready;
    assign w_eof_now    = r_eof_pending | bus.eof;
    assign w_in_range   = (64'(r_addr) < DEPTH);
    assign w_last       = (r_nib == c_kw'(c_nibbles - 1));
    assign w_word_next  = DATA_WIDTH'({r_word, w_nib});
    assign w_org_next   = ADDR_WIDTH'({r_org, w_nib});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_st_idle;
            r_nib         <= '0;
            r_word        <= '0;
            r_org         <= '0;
            r_org_any     <= 1'b0;
            r_addr        <= c_base;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= c_base;
            r_mem_din     <= '0;
            r_err         <= 2'b00;
            r_count       <= '0;
            r_eof_pending <= 1'b0;
        end else if (start) begin
            r_state       <= c_st_word;
            r_nib         <= '0;
            r_addr        <= c_base;
            r_mem_we      <= 1'b0;
            r_err         <= 2'b00;
            r_count       <= '0;
            r_eof_pending <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_st_word: begin
                    if (w_accept) begin
                        // A same-cycle eof waits until this character has been consumed
                        r_eof_pending <= w_eof_now;
                        if (w_is_hex) begin
                            r_word <= w_word_next;
                            if (w_last) begin
                                r_state  <= c_st_write;
                                r_nib    <= '0;
                                r_mem_we <= w_in_range;
                                if (w_in_range) begin
                                    r_mem_addr <= r_addr;
                                    r_mem_din  <= w_word_next;
                                end
                            end else begin
                                r_nib <= r_nib + c_kw'(1);
                            end
                        end else if (r_nib != '0) begin
                            r_state <= c_st_err;
                            r_err   <= (w_is_sep || w_is_hash || w_is_at) ? c_err_split : c_err_char;
                        end else if (w_is_hash) begin
                            r_state <= c_st_comment;
                        end else if (w_is_at) begin
                            r_state   <= c_st_org;
                            r_org     <= '0;
                            r_org_any <= 1'b0;
                        end else if (!w_is_sep) begin
                            r_state <= c_st_err;
                            r_err   <= c_err_char;
                        end
                    end else if (w_eof_now) begin
                        r_eof_pending <= 1'b0;
                        if (r_nib == '0) begin
                            r_state <= c_st_done;
                        end else begin
                            r_state <= c_st_err;
                            r_err   <= c_err_split;
                        end
                    end
                end
                c_st_org: begin
                    if (w_accept) begin
                        r_eof_pending <= w_eof_now;
                        if (w_is_hex) begin
                            r_org     <= w_org_next;
                            r_org_any <= 1'b1;
                        end else if (w_is_sep || w_is_hash) begin
                            if (r_org_any) begin
                                r_addr  <= r_org;
                                r_state <= w_is_hash ? c_st_comment : c_st_word;
                            end else begin
                                r_state <= c_st_err;
                                r_err   <= c_err_split;
                            end
                        end else begin
                            r_state <= c_st_err;
                            r_err   <= c_err_char;
                        end
                    end else if (w_eof_now) begin
                        r_eof_pending <= 1'b0;
                        r_state       <= c_st_err;
                        r_err         <= c_err_split;
                    end
                end
                c_st_comment: begin
                    if (w_accept) begin
                        r_eof_pending <= w_eof_now;
                        if (w_is_lf) begin
                            r_state <= c_st_word;
                        end
                    end else if (w_eof_now) begin
                        r_eof_pending <= 1'b0;
                        r_state       <= c_st_done;
                    end
                end
                c_st_write: begin
                    r_eof_pending <= w_eof_now;
                    if (w_in_range) begin
                        r_addr  <= r_addr + ADDR_WIDTH'(1);
                        r_state <= c_st_word;
                        if (r_count != '1) begin
                            r_count <= r_count + COUNT_WIDTH'(1);
                        end
                    end else begin
                        r_state <= c_st_err;
                        r_err   <= c_err_range;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.char_ready = w_char_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;

    assign busy        = w_char_ready || (r_state == c_st_write);
    assign done        = (r_state == c_st_done);
    assign cpu_reset_n = (r_state == c_st_done);
    assign error_code  = r_err;
    assign word_count  = r_count;
endmodule
`default_nettype wire

// File: tb/tb_fw_hex_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fw_hex_loader
//  Description : Directed vector bench for fw_hex_loader (three configurations).
//  Revision    : 1.0
// ============================================================================
module tb_fw_hex_loader;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_a, start_b, start_c;
    logic [7:0]  ch;
    logic        cv;
    logic        eof;
    int          sel;
    logic        cur_ready;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    fw_hex_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8))  ifa ();
    fw_hex_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8))  ifb ();
    fw_hex_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) ifc ();

    assign ifa.char_in = ch; assign ifa.char_valid = cv; assign ifa.eof = eof;
    assign ifb.char_in = ch; assign ifb.char_valid = cv; assign ifb.eof = eof;
    assign ifc.char_in = ch; assign ifc.char_valid = cv; assign ifc.eof = eof;

    logic        busy_a, done_a, cpu_a, busy_b, done_b, cpu_b, busy_c, done_c, cpu_c;
    logic [1:0]  err_a, err_b, err_c;
    logic [16:0] cnt_a, cnt_b, cnt_c;

    fw_hex_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR('h0200), .DEPTH(65536),
                    .COUNT_WIDTH(17)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .bus(ifa), .busy(busy_a),
        .done(done_a), .error_code(err_a), .word_count(cnt_a), .cpu_reset_n(cpu_a));

    fw_hex_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(2), .DEPTH(4),
                    .COUNT_WIDTH(17)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .bus(ifb), .busy(busy_b),
        .done(done_b), .error_code(err_b), .word_count(cnt_b), .cpu_reset_n(cpu_b));

    fw_hex_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .BASE_ADDR('h0200), .DEPTH(65536),
                    .COUNT_WIDTH(17)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .bus(ifc), .busy(busy_c),
        .done(done_c), .error_code(err_c), .word_count(cnt_c), .cpu_reset_n(cpu_c));

    always_comb begin
        cur_ready = ifa.char_ready;
        if (sel == 1) cur_ready = ifb.char_ready;
        else if (sel == 2) cur_ready = ifc.char_ready;
    end

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t wq[$];

    always @(negedge clk) begin
        if (ifa.mem_we) wq.push_back({2'd0, ifa.mem_addr, 16'(ifa.mem_din)});
        if (ifb.mem_we) wq.push_back({2'd1, ifb.mem_addr, 16'(ifb.mem_din)});
        if (ifc.mem_we) wq.push_back({2'd2, ifc.mem_addr, ifc.mem_din});
    end

    typedef struct {
        string            text;
        bit               use_eof;
        int               nwr;
        logic [0:4][15:0] waddr;
        logic [0:4][15:0] wdata;
        int               count;
        bit               done_e;
        logic [1:0]       err;
    } vec_t;
    vec_t vt[$];

    task automatic add(input string t, input bit e, input int n, input logic [0:4][15:0] a,
                       input logic [0:4][15:0] d, input int c, input bit dn, input logic [1:0] er);
        vec_t v;
        v.text = t; v.use_eof = e; v.nwr = n; v.waddr = a; v.wdata = d;
        v.count = c; v.done_e = dn; v.err = er;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A character the DUT never accepts simply ends the stream
    task automatic send_char(input byte c, output bit ok);
        ok = 1'b0;
        cv = 1'b1;
        ch = c;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cur_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        cv = 1'b0;
    endtask

    task automatic send_str(input string s);
        bit ok;
        for (int j = 0; j < s.len(); j++) begin
            send_char(s[j], ok);
            if (!ok) break;
        end
    endtask

    task automatic pulse_start(input int s);
        @(posedge clk); #1;
        start_a = (s == 0); start_b = (s == 1); start_c = (s == 2);
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic pulse_eof();
        @(posedge clk); #1;
        eof = 1'b1;
        @(posedge clk); #1;
        eof = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        ch = 8'h00; cv = 1'b0; eof = 1'b0; sel = 0;

        add("A9 05 # lda\n8D 00 02\n", 1, 5,
            {16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0204},
            {16'hA9, 16'h05, 16'h8D, 16'h00, 16'h02}, 5, 1, 2'b00);
        add("aB\nf0", 1, 2, {16'h0200, 16'h0201, 48'h0}, {16'hAB, 16'hF0, 48'h0}, 2, 1, 2'b00);
        add("@0300 EA @10 4C\n", 1, 2, {16'h0300, 16'h0010, 48'h0}, {16'hEA, 16'h4C, 48'h0},
            2, 1, 2'b00);
        add("A 9", 0, 0, '0, '0, 0, 0, 2'b10);
        add("G1", 0, 0, '0, '0, 0, 0, 2'b01);
        add("@ 12", 0, 0, '0, '0, 0, 0, 2'b10);
        add("1#\n", 0, 0, '0, '0, 0, 0, 2'b10);
        add("5", 1, 0, '0, '0, 0, 0, 2'b10);
        add("@FFFF12 77\t\r\n", 1, 1, {16'hFF12, 64'h0}, {16'h77, 64'h0}, 1, 1, 2'b00);
        add("#x@ zz\n0c", 1, 1, {16'h0200, 64'h0}, {16'h0C, 64'h0}, 1, 1, 2'b00);
        add("3C # tail", 1, 1, {16'h0200, 64'h0}, {16'h3C, 64'h0}, 1, 1, 2'b00);

        repeat (2) @(negedge clk);
        check("rst char_ready", 32'(ifa.char_ready), 0);
        check("rst mem_we", 32'(ifa.mem_we), 0);
        check("rst mem_addr", 32'(ifa.mem_addr), 32'h0200);
        check("rst mem_din", 32'(ifa.mem_din), 0);
        check("rst busy", 32'(busy_a), 0);
        check("rst done", 32'(done_a), 0);
        check("rst error_code", 32'(err_a), 0);
        check("rst word_count", 32'(cnt_a), 0);
        check("rst cpu_reset_n", 32'(cpu_a), 0);
        check("rst b mem_addr", 32'(ifb.mem_addr), 32'h2);
        @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (vt[i]) begin
            wq.delete();
            pulse_start(0);
            send_str(vt[i].text);
            if (vt[i].use_eof) pulse_eof();
            repeat (8) @(negedge clk);
            check($sformatf("v%0d nwrites", i), 32'(wq.size()), 32'(vt[i].nwr));
            for (int k = 0; k < vt[i].nwr; k++) begin
                if (k < wq.size()) begin
                    check($sformatf("v%0d w%0d addr", i, k), 32'(wq[k].addr), 32'(vt[i].waddr[k]));
                    check($sformatf("v%0d w%0d data", i, k), 32'(wq[k].data), 32'(vt[i].wdata[k]));
                end
            end
            check($sformatf("v%0d count", i), 32'(cnt_a), 32'(vt[i].count));
            check($sformatf("v%0d done", i), 32'(done_a), 32'(vt[i].done_e));
            check($sformatf("v%0d error_code", i), 32'(err_a), 32'(vt[i].err));
            check($sformatf("v%0d cpu_reset_n", i), 32'(cpu_a), 32'(vt[i].done_e));
            check($sformatf("v%0d busy", i), 32'(busy_a), 0);
        end

        // restart in the middle of a stream
        wq.delete();
        pulse_start(0);
        send_str("11 22 3");
        pulse_start(0);
        send_str("44");
        pulse_eof();
        repeat (8) @(negedge clk);
        check("restart nwrites", 32'(wq.size()), 3);
        if (wq.size() == 3) begin
            check("restart addr", 32'(wq[2].addr), 32'h0200);
            check("restart data", 32'(wq[2].data), 32'h44);
        end
        check("restart count", 32'(cnt_a), 1);
        check("restart done", 32'(done_a), 1);

        // asynchronous reset mid-word
        wq.delete();
        pulse_start(0);
        send_str("@0400 12 3");
        @(negedge clk);
        check("pre-rst count", 32'(cnt_a), 1);
        reset_n = 1'b0;
        #1;
        check("arst count", 32'(cnt_a), 0);
        check("arst mem_addr", 32'(ifa.mem_addr), 32'h0200);
        check("arst mem_din", 32'(ifa.mem_din), 0);
        check("arst busy", 32'(busy_a), 0);
        check("arst char_ready", 32'(ifa.char_ready), 0);
        repeat (3) @(negedge clk);
        check("arst nwrites", 32'(wq.size()), 1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // DEPTH=4, BASE_ADDR=2: third word is out of range
        sel = 1;
        wq.delete();
        pulse_start(1);
        send_str("01 02 03");
        repeat (8) @(negedge clk);
        check("depth nwrites", 32'(wq.size()), 2);
        if (wq.size() == 2) begin
            check("depth w0", {wq[0].id, wq[0].addr, wq[0].data[7:0]}, {2'd1, 16'h2, 8'h01});
            check("depth w1", {wq[1].id, wq[1].addr, wq[1].data[7:0]}, {2'd1, 16'h3, 8'h02});
        end
        check("depth error_code", 32'(err_b), 3);
        check("depth count", 32'(cnt_b), 2);
        check("depth cpu_reset_n", 32'(cpu_b), 0);

        // DATA_WIDTH=16: write latency and a character held across WRITE
        sel = 2;
        wq.delete();
        pulse_start(2);
        send_str("12AB");
        cv = 1'b1;
        ch = "5";
        @(negedge clk);
        check("w16 mem_we latency", 32'(ifc.mem_we), 1);
        check("w16 ready in write", 32'(ifc.char_ready), 0);
        check("w16 mem_din", 32'(ifc.mem_din), 32'h12AB);
        check("w16 mem_addr", 32'(ifc.mem_addr), 32'h0200);
        send_str("5678 34");
        pulse_eof();
        repeat (8) @(negedge clk);
        check("w16 nwrites", 32'(wq.size()), 2);
        if (wq.size() == 2) begin
            check("w16 held word", {wq[1].addr, wq[1].data}, {16'h0201, 16'h5678});
        end
        check("w16 error_code", 32'(err_c), 2);
        check("w16 count", 32'(cnt_c), 2);
        check("w16 cpu_reset_n", 32'(cpu_c), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
